// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int HALF_BIT         = CLKS_PER_BIT_DEF / 2;
  localparam int CNT_W            = $clog2(CLKS_PER_BIT_DEF);

  // Returns 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional even parity, stop bit.
// Output strobes are single-cycle, registered, and mutually exclusive.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output rx_state_t         state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  rx_state_t         state_q;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              rx_s;
  logic              parity_ok;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  assign parity_ok = (PARITY_EN == 0) || ((even_parity(32'(shift_q)) ^ par_q) == 1'b0);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // A start bit that is no longer low at its midpoint is treated as a glitch.
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_q[idx_q] <= rx_s;
            idx_q          <= idx_q + IW'(1);
            cnt_q          <= '0;
            if (idx_q == IDX_LAST) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) begin
            par_q   <= rx_s;
            cnt_q   <= '0;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
              if (parity_ok) begin
                data_out   <= shift_q;
                data_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
              end
            end else begin
              // Bad stop bit: parity is meaningless, wait out the low line.
              frame_err <= 1'b1;
              state_q   <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: stimulus pushes expected strobes, a negedge monitor pops and checks.
module tb_serial_frame_rx;
  import serial_rx_pkg::*;

  localparam int CPB     = 16;
  localparam int DW      = 7;
  localparam int LAT     = 152;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_PAR   = 2'd1;
  localparam logic [1:0] K_FRM   = 2'd2;

  // Handshake: each data_valid/parity_err/frame_err strobe is a single cycle;
  // the monitor treats every strobe cycle as exactly one presented result.

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
  rx_state_t     state_dbg;

  // clock / reset block
  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // Downstream enable register fed by data_valid/data_out.
  logic [DW-1:0] q_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_reg <= '0;
    else if (data_valid) q_reg <= data_out;
  end

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]    kind_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // scoreboard monitor
  int            rise_cyc   = 0;
  int            last_v_cyc = 0;
  int            prev_v_cyc = 0;
  logic          busy_prev  = 1'b0;
  logic          v_prev     = 1'b0;
  logic [DW-1:0] v_data     = '0;

  always @(negedge clk) begin
    logic [1:0]    k;
    logic [1:0]    ek;
    logic [DW-1:0] ed;
    if (reset) begin
      busy_prev = 1'b0;
      v_prev    = 1'b0;
    end else begin
      if (busy && !busy_prev) rise_cyc = cyc;
      busy_prev = busy;
      if (v_prev) check("q_after_valid", 32'(q_reg), 32'(v_data));
      v_prev = 1'b0;
      if ((int'(data_valid) + int'(parity_err) + int'(frame_err)) > 1) begin
        fail_now("strobe_onehot");
        kind_q.delete();
        exp_q.delete();
      end else if (data_valid || parity_err || frame_err) begin
        k = data_valid ? K_VALID : (parity_err ? K_PAR : K_FRM);
        if (kind_q.size() == 0) begin
          check("unexpected_strobe", 32'(k), 32'hFFFF_FFFF);
        end else begin
          ek = kind_q.pop_front();
          ed = exp_q.pop_front();
          check("strobe_kind", 32'(k), 32'(ek));
          check("data_out", 32'(data_out), 32'(ed));
          check("latency", 32'(cyc - rise_cyc), 32'(LAT));
          if (data_valid) begin
            prev_v_cyc = last_v_cyc;
            last_v_cyc = cyc;
            v_prev     = 1'b1;
            v_data     = ed;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s,
                            input logic [1:0] k, input logic [DW-1:0] ed);
    kind_q.push_back(k);
    exp_q.push_back(ed);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic hold_line(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (kind_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (kind_q.size() != 0) begin
      fail_now("drain_timeout");
      kind_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            rise_before;
    logic [DW-1:0] d33;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    hold_line(1'b1, 20);

    // 1: good frame
    send_frame(7'b1010101, 1'b0, 1'b1, K_VALID, 7'b1010101);
    hold_line(1'b1, 20);
    drain(50);

    // 2: wrong parity, data_out holds
    send_frame(7'b0001110, 1'b0, 1'b1, K_PAR, 7'b1010101);
    hold_line(1'b1, 20);
    drain(50);

    // 3: bad stop, line held low
    send_frame(7'b1111111, 1'b1, 1'b0, K_FRM, 7'b1010101);
    hold_line(1'b0, 40 * CPB);
    check("break_state", 32'(state_dbg), 32'(BREAK));
    check("break_busy", 32'(busy), 32'h1);
    hold_line(1'b1, 20);
    check("break_exit_busy", 32'(busy), 32'h0);
    drain(50);

    // 4: short glitch in IDLE
    rise_before = rise_cyc;
    hold_line(1'b0, 5);
    hold_line(1'b1, 30);
    check("glitch_seen", 32'(rise_cyc > rise_before), 32'h1);
    check("glitch_busy", 32'(busy), 32'h0);
    check("glitch_state", 32'(state_dbg), 32'(IDLE));
    check("glitch_data_out", 32'(data_out), 32'(7'b1010101));

    // 5: back-to-back frames
    send_frame(7'h2A, 1'b1, 1'b1, K_VALID, 7'h2A);
    send_frame(7'h15, 1'b1, 1'b1, K_VALID, 7'h15);
    hold_line(1'b1, 20);
    drain(50);
    check("b2b_spacing", 32'(last_v_cyc - prev_v_cyc), 32'd160);

    // 6: reset in the 4th data bit, then a full frame
    d33 = 7'h33;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d33[i]);
    hold_line(d33[3], CPB / 2);
    reset = 1'b1;
    rx    = 1'b1;
    #1;
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    hold_line(1'b1, 40);
    check("postrst_data_out", 32'(data_out), 32'h0);
    check("postrst_state", 32'(state_dbg), 32'(IDLE));
    send_frame(7'h33, 1'b0, 1'b1, K_VALID, 7'h33);
    hold_line(1'b1, 20);
    drain(50);
    check("reg_q_final", 32'(q_reg), 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
